// File: rtl/key_event_gen.sv
// Turns debounced key levels into one-cycle press/release pulses, an encoded key code and
// an optional auto-repeat stream for one held key (enabled by defining KEY_EVENT_REPEAT_EN).
module key_event_gen #(
  parameter int unsigned W             = 1,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  localparam int unsigned KW           = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  sw_in_i,
  output logic [W-1:0]  press_o,
  output logic [W-1:0]  release_o,
  output logic [W-1:0]  repeat_o,
  output logic          key_valid_o,
  output logic [KW-1:0] key_code_o
);

  logic [W-1:0]  sw_prev_q;
  logic [W-1:0]  new_press_c;
  logic [KW-1:0] low_idx_c;
  logic [W-1:0]  press_q, release_q;
  logic          key_valid_q, key_valid_d;
  logic [KW-1:0] key_code_q, key_code_d;

  assign new_press_c = sw_in_i & ~sw_prev_q;

  // Lowest-indexed key among this cycle's new presses (0 when none).
  always_comb begin
    low_idx_c = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (new_press_c[i]) low_idx_c = KW'(i);
    end
  end

  // Loading sw_prev from sw_in in reset suppresses presses for keys held through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_prev_q   <= sw_in_i;
      press_q     <= '0;
      release_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      sw_prev_q   <= sw_in_i;
      press_q     <= new_press_c;
      release_q   <= ~sw_in_i & sw_prev_q;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign press_o     = press_q;
  assign release_o   = release_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

`ifdef KEY_EVENT_REPEAT_EN
  localparam int unsigned MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] trk_q, trk_d;
  logic [W-1:0]  repeat_q, repeat_d;
  logic          trk_held_c;
  logic          fire_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      trk_q    <= '0;
      repeat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      trk_q    <= trk_d;
      repeat_q <= repeat_d;
    end
  end

  // Level of the tracked key; looped compare keeps the select in range for any W.
  always_comb begin
    trk_held_c = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (KW'(i) == trk_q) trk_held_c = sw_in_i[i];
    end
  end

  // A new press always wins: it retargets even when the tracked key releases or the timer expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trk_d   = trk_q;
    fire_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|new_press_c) begin
          state_d = ST_DELAY;
          trk_d   = low_idx_c;
          cnt_d   = '0;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (|new_press_c) begin
          state_d = ST_DELAY;
          trk_d   = low_idx_c;
          cnt_d   = '0;
        end else if (!trk_held_c) begin
          state_d = ST_IDLE;
        end else if (state_q == ST_DELAY && cnt_q == CW'(HOLD_CYCLES - 1)) begin
          fire_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else if (state_q == ST_REPEAT && cnt_q == CW'(REPEAT_CYCLES - 1)) begin
          fire_c  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    repeat_d = '0;
    for (int i = 0; i < W; i++) begin
      if (KW'(i) == trk_q) repeat_d[i] = fire_c;
    end
    key_valid_d = (|new_press_c) | fire_c;
    if (|new_press_c)  key_code_d = low_idx_c;
    else if (fire_c)   key_code_d = trk_q;
    else               key_code_d = '0;
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o    = '0;
  assign key_valid_d = |new_press_c;
  assign key_code_d  = low_idx_c;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen (W=4, HOLD=8, REPEAT=4) against a timing-arithmetic model.
module tb_key_event_gen;

  localparam int unsigned W    = 4;
  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 4;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_in_i;
  logic [W-1:0] press_o, release_o, repeat_o;
  logic         key_valid_o;
  logic [1:0]   key_code_o;

  key_event_gen #(.W(W), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_in_i     (sw_in_i),
    .press_o     (press_o),
    .release_o   (release_o),
    .repeat_o    (repeat_o),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state: tracking expressed as start cycle + elapsed-time arithmetic.
  logic [W-1:0] m_prev = '0;
  bit           m_on   = 1'b0;
  int           m_trk  = 0;
  int           m_start = 0;
  logic [W-1:0] e_press, e_rel, e_rep;
  logic         e_valid;
  logic [1:0]   e_code;

  logic [14:0] dut_vec, exp_vec;
  assign dut_vec = {press_o, release_o, repeat_o, key_valid_o, key_code_o};
  assign exp_vec = {e_press, e_rel, e_rep, e_valid, e_code};

  task automatic model(input logic [W-1:0] sw, input logic rst);
    logic [W-1:0] np;
    int low, el;
    bit fire;
    np = sw & ~m_prev;
    fire = 1'b0;
    low = 0;
    for (int i = W - 1; i >= 0; i--) if (np[i]) low = i;
    if (rst) begin
      e_press = '0; e_rel = '0; e_rep = '0; e_valid = 1'b0; e_code = '0;
      m_on = 1'b0;
    end else begin
      e_press = np;
      e_rel   = ~sw & m_prev;
      if (np != 0) begin
        m_on = 1'b1; m_trk = low; m_start = cyc;
      end else if (m_on) begin
        if (!sw[m_trk]) m_on = 1'b0;
        else begin
          el = cyc - m_start;
          fire = REP_EN && (el == HOLD || (el > HOLD && (el - HOLD) % REP == 0));
        end
      end
      e_rep   = fire ? W'(1 << m_trk) : '0;
      e_valid = (np != 0) || fire;
      e_code  = (np != 0) ? 2'(low) : (fire ? 2'(m_trk) : 2'd0);
    end
    m_prev = sw;
  endtask

  // Drive at negedge, clock once, update model; returns at the next negedge for sampling.
  task automatic step(input logic [W-1:0] sw, input logic rst);
    sw_in_i = sw;
    reset   = rst;
    @(posedge clk);
    cyc++;
    model(sw, rst);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(4'b1111, 1'b1);
      n_cmp++;
      if (dut_vec !== 15'd0) begin
        n_fail++; $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc, dut_vec);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, 1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec || press_o !== 4'b0000) begin
        n_fail++; $display("FAIL reset_held_keys cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
      end
    end
    step(4'b0000, 1'b0);
    n_cmp++;
    if (release_o !== 4'b1111) begin
      n_fail++; $display("FAIL reset_release cyc=%0d got=%b want=1111", cyc, release_o);
    end
  endtask

  task automatic test_single_press();
    logic [W-1:0] pat [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    for (int k = 0; k < 6; k++) begin
      step(pat[k], 1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL single_press cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
      end
      if (k == 1) begin
        n_cmp++;
        if (press_o !== 4'b0100 || key_valid_o !== 1'b1 || key_code_o !== 2'd2) begin
          n_fail++; $display("FAIL single_press_code got=%b/%b/%0d want=0100/1/2",
                             press_o, key_valid_o, key_code_o);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (release_o !== 4'b0100 || repeat_o !== 4'b0000) begin
          n_fail++; $display("FAIL single_release got=%b/%b want=0100/0000", release_o, repeat_o);
        end
      end
    end
  endtask

  task automatic test_hold_repeat();
    int reps = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL hold_repeat cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
      end
      if (repeat_o == 4'b0001 && key_code_o == 2'd0 && key_valid_o) reps++;
    end
    for (int k = 0; k < 6; k++) begin
      step(4'b0000, 1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec || repeat_o !== 4'b0000) begin
        n_fail++; $display("FAIL hold_release cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
      end
    end
    n_cmp++;
    if (reps !== (REP_EN ? 3 : 0)) begin
      n_fail++; $display("FAIL hold_repeat_count got=%0d want=%0d", reps, REP_EN ? 3 : 0);
    end
  endtask

  task automatic test_multi_press();
    int reps1 = 0, reps3 = 0;
    for (int k = 0; k < 14; k++) begin
      step(4'b1010, 1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL multi_press cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
      end
      if (k == 0) begin
        n_cmp++;
        if (press_o !== 4'b1010 || key_code_o !== 2'd1) begin
          n_fail++; $display("FAIL multi_press_code got=%b/%0d want=1010/1", press_o, key_code_o);
        end
      end
      if (repeat_o[1]) reps1++;
      if (repeat_o[3]) reps3++;
    end
    step(4'b0000, 1'b0);
    n_cmp++;
    if (reps1 !== (REP_EN ? 2 : 0) || reps3 !== 0) begin
      n_fail++; $display("FAIL multi_repeat got=%0d/%0d want=%0d/0", reps1, reps3, REP_EN ? 2 : 0);
    end
  endtask

  task automatic test_retarget();
    int r0 = 0, r3 = 0;
    for (int k = 0; k < 14; k++) step(4'b0001, 1'b0);
    for (int j = 0; j < 10; j++) begin
      step(4'b1001, 1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL retarget cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
      end
      if (j == 0) begin
        n_cmp++;
        if (press_o !== 4'b1000 || key_code_o !== 2'd3 || key_valid_o !== 1'b1) begin
          n_fail++; $display("FAIL retarget_press got=%b/%0d want=1000/3", press_o, key_code_o);
        end
      end
      if (repeat_o[0]) r0++;
      if (repeat_o[3]) r3++;
    end
    step(4'b0000, 1'b0);
    n_cmp++;
    if (r0 !== 0 || r3 !== (REP_EN ? 1 : 0)) begin
      n_fail++; $display("FAIL retarget_repeat got=%0d/%0d want=0/%0d", r0, r3, REP_EN ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    int reps = 0;
    step(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    n_cmp++;
    if (dut_vec !== 15'd0) begin
      n_fail++; $display("FAIL reset_mid cyc=%0d got=%h want=0", cyc, dut_vec);
    end
    for (int k = 0; k < 14; k++) begin
      step(4'b0010, 1'b0);
      if (repeat_o != 4'b0000 || press_o != 4'b0000) reps++;
    end
    n_cmp++;
    if (reps !== 0) begin
      n_fail++; $display("FAIL reset_mid_after got=%0d events want=0", reps);
    end
    step(4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] sw = '0;
    logic rst;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(0, 15) == 0) sw[b] = ~sw[b];
      rst = ($urandom_range(0, 149) == 0);
      step(sw, rst);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL random cyc=%0d sw=%b got=%h want=%h", cyc, sw, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    sw_in_i = '0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_multi_press();
    test_retarget();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
